coeff_loader: RTL and testbench

- Receives a 5x5 filter-coefficient packet over a byte stream (valid/ready), checks its checksum and stages it internally.
- Writes the coefficients into port A of the 32-bit coefficient dual-port BRAM, addresses 0..24, which bram2coeff reads.
- Writes are held until just after bram2coeff's frame-start read burst, so a frame never sees a mix of old and new coefficients.
- Sits between the host/UART byte interface and the coefficient BRAM.

---
 rtl/coeff_loader_if.sv | 18 +
 rtl/coeff_loader.sv | 158 +++++++++++++++
 tb/tb_coeff_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_loader_if.sv
// Byte-stream sink and BRAM port-A write bus of the coefficient loader.
// The slave modport is the loader's view; the master modport is the host/BRAM side.
interface coeff_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;

    modport slave  (input  s_data, s_valid,
                    output s_ready, bram_we, bram_addr, bram_wdata);
    modport master (output s_data, s_valid,
                    input  s_ready, bram_we, bram_addr, bram_wdata);
endinterface

// File: rtl/coeff_loader.sv
// Receives a checksummed 5x5 coefficient packet, stages it, and writes it to the
// coefficient BRAM a guard interval after vsync so the reader's burst sees one set.
module coeff_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         NCOEFF    = 25,
    parameter int         ADDR_W    = 6,
    parameter int         DATA_W    = 32,
    parameter int         GUARD     = 32
) (
    input  logic          clk,
    input  logic          rst,
    coeff_loader_if.slave bus,
    input  logic          vs_i,
    output logic          busy,
    output logic          load_done,
    output logic          load_err
);
    localparam int IDX_W = $clog2(NCOEFF);
    localparam int CNT_W = $clog2(GUARD + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCOEFF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_LO, S_RX_HI, S_RX_CSUM, S_WAIT_VS, S_WAIT_GUARD, S_WRITE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_inc;
    logic [7:0]        r_sum, w_sum_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_vs_d;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_busy, r_done, w_done_nxt, r_err, w_err_nxt, r_ready;
    logic              w_acc, w_vs_rise, w_lo_we, w_hi_we;
    logic [15:0]       r_stage [NCOEFF];

    function automatic logic [DATA_W-1:0] sx(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    assign w_acc     = bus.s_valid & r_ready;
    assign w_vs_rise = vs_i & ~r_vs_d;
    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_we     = 1'b0;
        case (r_state)
            S_IDLE: if (w_acc && bus.s_data == SYNC_BYTE) begin
                w_state_nxt = S_RX_LO;
                w_idx_nxt   = '0;
                w_sum_nxt   = '0;
            end
            S_RX_LO: if (w_acc) begin
                w_lo_we     = 1'b1;
                w_sum_nxt   = r_sum + bus.s_data;
                w_state_nxt = S_RX_HI;
            end
            S_RX_HI: if (w_acc) begin
                w_hi_we   = 1'b1;
                w_sum_nxt = r_sum + bus.s_data;
                if (r_idx == LAST) begin
                    w_state_nxt = S_RX_CSUM;
                end else begin
                    w_idx_nxt   = w_idx_inc;
                    w_state_nxt = S_RX_LO;
                end
            end
            S_RX_CSUM: if (w_acc) begin
                if (bus.s_data == r_sum) begin
                    w_state_nxt = S_WAIT_VS;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_VS: if (w_vs_rise) begin
                w_cnt_nxt   = CNT_W'(GUARD - 1);
                w_state_nxt = S_WAIT_GUARD;
            end
            // Outputs are registered, so the first write is launched as the counter hits 0.
            S_WAIT_GUARD: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_WRITE;
                    w_idx_nxt   = '0;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = sx(r_stage[0]);
                end
            end
            S_WRITE: begin
                if (r_idx == LAST) begin
                    w_done_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = w_idx_inc;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = ADDR_W'(w_idx_inc);
                    w_wdata_nxt = sx(r_stage[w_idx_inc]);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_vs_d  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            for (int i = 0; i < NCOEFF; i++) r_stage[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vs_d  <= vs_i;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RX_LO) ||
                       (w_state_nxt == S_RX_HI) || (w_state_nxt == S_RX_CSUM);
            if (w_lo_we) r_stage[r_idx][7:0]  <= bus.s_data;
            if (w_hi_we) r_stage[r_idx][15:8] <= bus.s_data;
        end
    end

    assign bus.s_ready    = r_ready;
    assign bus.bram_we    = r_we;
    assign bus.bram_addr  = r_addr;
    assign bus.bram_wdata = r_wdata;
    assign busy           = r_busy;
    assign load_done      = r_done;
    assign load_err       = r_err;
endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: packets in, BRAM model and pulse timing checked.
module tb_coeff_loader;
    localparam int NCOEFF = 25;

    logic clk = 1'b0;
    logic rst;
    logic vs_i;
    logic busy, load_done, load_err;

    coeff_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    coeff_loader #(.SYNC_BYTE(8'hA5), .NCOEFF(NCOEFF), .ADDR_W(6), .DATA_W(32), .GUARD(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .vs_i(vs_i),
        .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [64];
    logic [15:0] c [NCOEFF];
    int wr_cnt, first_we, last_we, done_cnt, done_cyc, err_cnt, err_cyc;
    int acc_cyc, t_vs;
    int pass_cnt = 0, fail_cnt = 0, tot = 0;

    // BRAM model and pulse recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.bram_we) begin
            mem[bus.bram_addr] = bus.bram_wdata;
            wr_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
        end
        if (load_done) begin done_cnt++; done_cyc = cyc; end
        if (load_err)  begin err_cnt++;  err_cyc  = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clr();
        wr_cnt = 0; first_we = -1; last_we = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin n++; @(negedge clk); end
        if (n == 200) chk("byte_accept", {31'b0, bus.s_ready}, 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (gap) begin bus.s_valid = 1'b0; @(posedge clk); #1; end
    endtask

    task automatic send_pkt(input bit bad, input bit gap);
        logic [7:0] s;
        s = 8'h00;
        send_byte(8'hA5, gap);
        for (int i = 0; i < NCOEFF; i++) begin
            send_byte(c[i][7:0], gap);
            send_byte(c[i][15:8], gap);
            s = s + c[i][7:0] + c[i][15:8];
        end
        send_byte(bad ? s + 8'h01 : s, gap);
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_vs();
        @(posedge clk); #1;
        vs_i = 1'b1;
        t_vs = cyc;
        repeat (3) @(posedge clk);
        #1 vs_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin @(posedge clk); n++; end
        if (done_cnt == 0) chk("done_timeout", done_cnt, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < NCOEFF; i++)
            if (mem[i] !== {{16{c[i][15]}}, c[i]}) mism++;
        chk({tag, "_contents"}, mism, 32'd0);
        chk({tag, "_wr_cnt"}, wr_cnt, 32'd25);
        chk({tag, "_first_we"}, first_we, t_vs + 32);
        chk({tag, "_last_we"}, last_we, t_vs + 56);
        chk({tag, "_done_cyc"}, done_cyc, t_vs + 57);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0; vs_i = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
        mon_clr();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_we", {31'b0, bus.bram_we}, 32'd0);
        chk("rst_addr", {26'b0, bus.bram_addr}, 32'd0);
        chk("rst_wdata", bus.bram_wdata, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        chk("rst_ready", {31'b0, bus.s_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;

        // ramp -12..12, back-to-back bytes
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(i - 12);
        mon_clr();
        send_pkt(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_wait", {31'b0, busy}, 32'd1);
        chk("t1_ready_wait", {31'b0, bus.s_ready}, 32'd0);
        pulse_vs();
        wait_done(100);
        check_load("t1");
        chk("t1_addr0", mem[0], 32'hFFFFFFF4);
        chk("t1_addr12", mem[12], 32'h00000000);
        chk("t1_addr24", mem[24], 32'h0000000C);

        // bad checksum
        mon_clr();
        send_pkt(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_err_cyc", err_cyc, acc_cyc);
        chk("t2_err_cnt", err_cnt, 32'd1);
        chk("t2_busy", {31'b0, busy}, 32'd0);
        chk("t2_ready", {31'b0, bus.s_ready}, 32'd1);
        pulse_vs();
        repeat (50) @(posedge clk);
        #1;
        chk("t2_no_write", wr_cnt, 32'd0);

        // leading junk then a valid packet
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(i * 1000 - 9000);
        mon_clr();
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_pkt(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        pulse_vs();
        wait_done(100);
        check_load("t3");

        // gapped stream with sync-valued data bytes
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(i - 12);
        c[3] = 16'h12A5; c[7] = 16'hA5A5; c[10] = 16'h00A5;
        mon_clr();
        send_pkt(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        pulse_vs();
        wait_done(100);
        check_load("t4");
        chk("t4_addr3", mem[3], 32'h000012A5);
        chk("t4_addr7", mem[7], 32'hFFFFA5A5);

        // vsync already high at checksum; vsync pulse during WRITE
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(300 - i * 25);
        mon_clr();
        vs_i = 1'b1;
        send_pkt(1'b0, 1'b0);
        repeat (45) @(posedge clk);
        #1;
        chk("t5_held_no_write", wr_cnt, 32'd0);
        chk("t5_held_busy", {31'b0, busy}, 32'd1);
        vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 vs_i = 1'b1;
        t_vs = cyc;
        repeat (36) @(posedge clk);
        #1 vs_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 vs_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 vs_i = 1'b0;
        wait_done(100);
        check_load("t5");
        repeat (50) @(posedge clk);
        #1;
        chk("t5_no_extra", wr_cnt, 32'd25);

        // reset during WRITE at address 10, then a full reload
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(i * 77 + 5);
        mon_clr();
        send_pkt(1'b0, 1'b0);
        pulse_vs();
        n = 0;
        @(negedge clk);
        while (!(bus.bram_we && bus.bram_addr == 6'd10) && n < 200) begin n++; @(negedge clk); end
        if (n == 200) chk("t6_reach_addr10", {26'b0, bus.bram_addr}, 32'd10);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_we", {31'b0, bus.bram_we}, 32'd0);
        chk("t6_rst_addr", {26'b0, bus.bram_addr}, 32'd0);
        chk("t6_rst_wdata", bus.bram_wdata, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_ready", {31'b0, bus.s_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < NCOEFF; i++) c[i] = 16'(-i * 111);
        mon_clr();
        send_pkt(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        pulse_vs();
        wait_done(100);
        check_load("t6");

        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
